skein_key_schedule: RTL and testbench

- Threefish-1024 key-schedule generator for the Skein core.
- Accepts a raw 1024-bit key and 128-bit tweak, then builds the extended key: parity word k16 and tweak word t2.
- Streams the per-injection subkeys s = 0..NUM_SUBKEYS-1 over a valid/ready handshake, in ascending (encrypt) or descending (decrypt) order.
- Sits upstream of the key-injection stage and also exports the extended key/tweak in the injection stage's 1088/192-bit format.

---
 rtl/skein_key_schedule.sv | 125 ++++++++++++
 tb/tb_skein_key_schedule.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skein_key_schedule.sv
// Threefish-1024 key schedule: extends a raw key/tweak with parity words and
// streams the per-injection subkeys in encrypt or decrypt order.
module skein_key_schedule #(
  parameter int          NUM_SUBKEYS = 21,
  parameter logic [63:0] C240        = 64'h1BD11BDAA9FC1A22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [1023:0] key_in,
  input  logic [127:0]  tweak_in,
  input  logic          dir,
  output logic [1087:0] ext_key,
  output logic [191:0]  ext_tweak,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1023:0] subkey,
  output logic [4:0]    subkey_idx,
  output logic          subkey_last
);

  typedef enum logic [1:0] {IDLE, PREP, STREAM, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_SUBKEYS - 1);

  state_t        state, stateNext;
  logic [1023:0] keyLatch;
  logic [127:0]  tweakLatch;
  logic          dirReg;
  logic [1087:0] extKeyNext;
  logic [191:0]  extTweakNext;
  logic [4:0]    sInit, sStep;
  logic          atLast, xfer;

  function automatic logic isFinal(input logic [4:0] s, input logic d);
    return d ? (s == 5'd0) : (s == LAST_IDX);
  endfunction

  // Word i takes extended key word (s+i) mod 17; the top three words also
  // absorb the rotating tweak words and the injection counter.
  function automatic logic [1023:0] calcSubkey(input logic [1087:0] ek,
                                               input logic [191:0]  et,
                                               input logic [4:0]    s);
    logic [1023:0] sk;
    logic [63:0]   w;
    int            ki;
    sk = '0;
    for (int i = 0; i < 16; i++) begin
      ki = (int'(s) + i) % 17;
      w  = ek[64*ki +: 64];
      if (i == 13)      w = w + et[64*(int'(s) % 3) +: 64];
      else if (i == 14) w = w + et[64*((int'(s) + 1) % 3) +: 64];
      else if (i == 15) w = w + {59'd0, s};
      sk[64*i +: 64] = w;
    end
    return sk;
  endfunction

  always_comb begin
    logic [63:0] par;
    par = C240;
    for (int i = 0; i < 16; i++) par = par ^ keyLatch[64*i +: 64];
    extKeyNext   = {par, keyLatch};
    extTweakNext = {tweakLatch[63:0] ^ tweakLatch[127:64], tweakLatch};
  end

  assign load_ready  = (state == IDLE);
  assign out_valid   = (state == STREAM);
  assign xfer        = out_valid & out_ready;
  assign atLast      = isFinal(subkey_idx, dirReg);
  assign subkey_last = out_valid & atLast;
  assign sInit       = dirReg ? LAST_IDX : 5'd0;
  assign sStep       = dirReg ? subkey_idx - 5'd1 : subkey_idx + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (load_valid) stateNext = PREP;
      PREP:    stateNext = STREAM;
      STREAM:  if (xfer && atLast) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Raw key/tweak capture: only meaningful after a load, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && load_valid) begin
      keyLatch   <= key_in;
      tweakLatch <= tweak_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dirReg     <= 1'b0;
      ext_key    <= '0;
      ext_tweak  <= '0;
      subkey     <= '0;
      subkey_idx <= '0;
    end else begin
      case (state)
        IDLE: if (load_valid) dirReg <= dir;
        PREP: begin
          ext_key    <= extKeyNext;
          ext_tweak  <= extTweakNext;
          subkey     <= calcSubkey(extKeyNext, extTweakNext, sInit);
          subkey_idx <= sInit;
        end
        STREAM: if (xfer && !atLast) begin
          subkey     <= calcSubkey(ext_key, ext_tweak, sStep);
          subkey_idx <= sStep;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_skein_key_schedule.sv
// Scoreboard bench for skein_key_schedule: expected subkeys are queued at load
// time from an independent model of the Threefish-1024 key schedule.
module tb_skein_key_schedule;

  localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;
  localparam int          NSK  = 21;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [1023:0] key_in = '0;
  logic [127:0]  tweak_in = '0;
  logic          dir = 1'b0;
  logic [1087:0] ext_key;
  logic [191:0]  ext_tweak;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1023:0] subkey;
  logic [4:0]    subkey_idx;
  logic          subkey_last;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]    idx;
    logic [1023:0] sk;
    logic          last;
  } exp_t;
  exp_t q[$];

  skein_key_schedule #(.NUM_SUBKEYS(NSK), .C240(C240)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .key_in(key_in), .tweak_in(tweak_in), .dir(dir), .ext_key(ext_key),
    .ext_tweak(ext_tweak), .out_valid(out_valid), .out_ready(out_ready),
    .subkey(subkey), .subkey_idx(subkey_idx), .subkey_last(subkey_last)
  );

  always #5 clk = ~clk;

  function automatic logic [1023:0] refSubkey(input logic [1023:0] key,
                                              input logic [127:0] tw, input int s);
    logic [63:0]   k[17];
    logic [63:0]   t[3];
    logic [1023:0] r;
    k[16] = C240;
    for (int j = 0; j < 16; j++) begin
      k[j]  = key[64*j +: 64];
      k[16] = k[16] ^ k[j];
    end
    t[0] = tw[63:0];
    t[1] = tw[127:64];
    t[2] = t[0] ^ t[1];
    for (int i = 0; i < 16; i++) r[64*i +: 64] = k[(s + i) % 17];
    r[64*13 +: 64] = r[64*13 +: 64] + t[s % 3];
    r[64*14 +: 64] = r[64*14 +: 64] + t[(s + 1) % 3];
    r[64*15 +: 64] = r[64*15 +: 64] + 64'(s);
    return r;
  endfunction

  function automatic logic [63:0] refK16(input logic [1023:0] key);
    logic [63:0] p;
    p = C240;
    for (int j = 0; j < 16; j++) p = p ^ key[64*j +: 64];
    return p;
  endfunction

  function automatic int firstDiff(input logic [1023:0] a, input logic [1023:0] b);
    for (int w = 0; w < 16; w++) if (a[64*w +: 64] !== b[64*w +: 64]) return w;
    return 0;
  endfunction

  function automatic logic [1023:0] randKey();
    logic [1023:0] k;
    for (int w = 0; w < 32; w++) k[32*w +: 32] = $urandom;
    return k;
  endfunction

  task automatic pushSchedule(input logic [1023:0] key, input logic [127:0] tw, input logic d);
    exp_t e;
    q.delete();
    for (int n = 0; n < NSK; n++) begin
      int s;
      s      = d ? (NSK - 1 - n) : n;
      e.idx  = 5'(s);
      e.sk   = refSubkey(key, tw, s);
      e.last = (n == NSK - 1);
      q.push_back(e);
    end
  endtask

  task automatic doLoad(input logic [1023:0] key, input logic [127:0] tw, input logic d);
    @(negedge clk);
    key_in = key; tweak_in = tw; dir = d; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    key_in = ~key; tweak_in = ~tw; dir = ~d;
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = load_ready;
    end
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = out_valid;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1 || out_valid !== 1'b0 || subkey_last !== 1'b0 || subkey_idx !== 5'd0) begin
      failures++;
      $display("FAIL reset_ctrl ready/valid/last/idx act=%b/%b/%b/%0d exp=1/0/0/0",
               load_ready, out_valid, subkey_last, subkey_idx);
    end
    checks++;
    if (subkey !== '0 || ext_key !== '0 || ext_tweak !== '0) begin
      failures++;
      $display("FAIL reset_data subkey/ext_key/ext_tweak nonzero act=%h/%h/%h exp=0",
               subkey[63:0], ext_key[1087:1024], ext_tweak);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_key();
    exp_t e;
    int   got, cyc;
    bit   ok;
    out_ready = 1'b1;
    pushSchedule('0, '0, 1'b0);
    doLoad('0, '0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_prep_valid act=%b exp=0", out_valid);
    end
    got = 0; cyc = 0;
    while (got < NSK && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        e = q.pop_front();
        checks++;
        if (subkey !== e.sk || subkey_idx !== e.idx || subkey_last !== e.last) begin
          failures++;
          $display("FAIL zero_stream idx act=%0d exp=%0d last act=%b exp=%b word%0d act=%h exp=%h",
                   subkey_idx, e.idx, subkey_last, e.last, firstDiff(subkey, e.sk),
                   subkey[64*firstDiff(subkey, e.sk) +: 64], e.sk[64*firstDiff(subkey, e.sk) +: 64]);
        end
        if (e.idx == 5'd0) begin
          checks++;
          if (subkey !== '0) begin
            failures++;
            $display("FAIL zero_sk0 act_w0=%h exp=0", subkey[63:0]);
          end
        end
        if (e.idx == 5'd1) begin
          checks++;
          if (subkey[1023:960] !== 64'h1BD11BDAA9FC1A23 || subkey[959:0] !== '0) begin
            failures++;
            $display("FAIL zero_sk1 w15 act=%h exp=1bd11bdaa9fc1a23 low_nonzero=%b",
                     subkey[1023:960], |subkey[959:0]);
          end
        end
        got++;
      end
    end
    checks++;
    if (got != NSK || cyc != NSK) begin
      failures++;
      $display("FAIL zero_throughput transfers act=%0d exp=%0d cycles act=%0d exp=%0d", got, NSK, cyc, NSK);
    end
    checks++;
    if (ext_key[1087:1024] !== C240 || ext_key[1023:0] !== '0 || ext_tweak !== '0) begin
      failures++;
      $display("FAIL zero_ext k16 act=%h exp=%h", ext_key[1087:1024], C240);
    end
    waitIdle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL zero_idle timeout act=0 exp=1"); end
  endtask

  task automatic test_direction(input logic d);
    logic [1023:0] key;
    logic [127:0]  tw;
    exp_t          e;
    int            got, cyc;
    bit            ok;
    for (int i = 0; i < 16; i++) key[64*i +: 64] = 64'(i);
    tw = {64'h20, 64'h10};
    out_ready = 1'b0;
    pushSchedule(key, tw, d);
    checks++;
    if (load_ready !== 1'b1) begin failures++; $display("FAIL dir%0b_ready act=%b exp=1", d, load_ready); end
    doLoad(key, tw, d);
    waitValid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL dir%0b_valid timeout act=0 exp=1", d); end
    checks++;
    if (ext_key !== {C240, key} || ext_tweak !== {64'h30, tw}) begin
      failures++;
      $display("FAIL dir%0b_ext k16 act=%h exp=%h t2 act=%h exp=30", d, ext_key[1087:1024], C240, ext_tweak[191:128]);
    end
    checks++;
    if (!d && (subkey_idx !== 5'd0 || subkey[64*12 +: 64] !== 64'd12 || subkey[64*13 +: 64] !== 64'h1D ||
               subkey[64*14 +: 64] !== 64'h2E || subkey[64*15 +: 64] !== 64'hF || subkey[63:0] !== 64'd0)) begin
      failures++;
      $display("FAIL asc_first idx act=%0d exp=0 w13..15 act=%h %h %h exp=1d 2e f", subkey_idx,
               subkey[64*13 +: 64], subkey[64*14 +: 64], subkey[64*15 +: 64]);
    end
    if (d && (subkey_idx !== 5'd20 || subkey[63:0] !== 64'd3 || subkey[64*13 +: 64] !== 64'h1BD11BDAA9FC1A52 ||
              subkey[64*14 +: 64] !== 64'h10 || subkey[64*15 +: 64] !== 64'h15)) begin
      failures++;
      $display("FAIL desc_first idx act=%0d exp=20 w0/13/14/15 act=%h %h %h %h exp=3 1bd11bdaa9fc1a52 10 15",
               subkey_idx, subkey[63:0], subkey[64*13 +: 64], subkey[64*14 +: 64], subkey[64*15 +: 64]);
    end
    out_ready = 1'b1;
    got = 0; cyc = 0;
    if (out_valid) begin
      e = q.pop_front();
      checks++;
      if (subkey !== e.sk || subkey_idx !== e.idx || subkey_last !== e.last) begin
        failures++;
        $display("FAIL dir%0b_stream idx act=%0d exp=%0d", d, subkey_idx, e.idx);
      end
      got++;
    end
    while (got < NSK && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        e = q.pop_front();
        checks++;
        if (subkey !== e.sk || subkey_idx !== e.idx || subkey_last !== e.last) begin
          failures++;
          $display("FAIL dir%0b_stream idx act=%0d exp=%0d last act=%b exp=%b word%0d act=%h exp=%h",
                   d, subkey_idx, e.idx, subkey_last, e.last, firstDiff(subkey, e.sk),
                   subkey[64*firstDiff(subkey, e.sk) +: 64], e.sk[64*firstDiff(subkey, e.sk) +: 64]);
        end
        got++;
      end
    end
    checks++;
    if (got != NSK) begin failures++; $display("FAIL dir%0b_count act=%0d exp=%0d", d, got, NSK); end
    waitIdle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL dir%0b_idle timeout act=0 exp=1", d); end
  endtask

  task automatic test_backpressure();
    logic [1023:0] key;
    logic [127:0]  tw;
    logic [1023:0] prevSk;
    logic [4:0]    prevIdx;
    logic          prevLast;
    exp_t          e;
    bit            prevHold, ok;
    int            got, cyc, stallCnt;
    key = randKey();
    tw  = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    pushSchedule(key, tw, 1'b0);
    doLoad(key, tw, 1'b0);
    got = 0; cyc = 0; stallCnt = 0; prevHold = 1'b0;
    prevSk = '0; prevIdx = '0; prevLast = 1'b0;
    while (got < NSK && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (prevHold) begin
        checks++;
        if (out_valid !== 1'b1 || subkey !== prevSk || subkey_idx !== prevIdx || subkey_last !== prevLast) begin
          failures++;
          $display("FAIL bp_stable valid act=%b exp=1 idx act=%0d exp=%0d", out_valid, subkey_idx, prevIdx);
        end
      end
      if (out_valid && subkey_idx == 5'd7 && stallCnt < 5) begin
        out_ready = 1'b0;
        stallCnt++;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_valid && out_ready) begin
        e = q.pop_front();
        checks++;
        if (subkey !== e.sk || subkey_idx !== e.idx || subkey_last !== e.last) begin
          failures++;
          $display("FAIL bp_stream idx act=%0d exp=%0d last act=%b exp=%b word%0d act=%h exp=%h",
                   subkey_idx, e.idx, subkey_last, e.last, firstDiff(subkey, e.sk),
                   subkey[64*firstDiff(subkey, e.sk) +: 64], e.sk[64*firstDiff(subkey, e.sk) +: 64]);
        end
        got++;
      end
      prevHold = out_valid && !out_ready;
      prevSk = subkey; prevIdx = subkey_idx; prevLast = subkey_last;
    end
    checks++;
    if (got != NSK || stallCnt != 5) begin
      failures++;
      $display("FAIL bp_count transfers act=%0d exp=%0d stalls act=%0d exp=5", got, NSK, stallCnt);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra_transfer out_valid act=%b exp=0", out_valid); end
    out_ready = 1'b1;
    waitIdle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_idle timeout act=0 exp=1"); end
  endtask

  task automatic test_load_ignored();
    logic [1023:0] keyA, keyB;
    logic [127:0]  twA, twB;
    exp_t          e;
    int            got, cyc;
    bit            ok;
    keyA = randKey(); keyB = randKey();
    twA = {$urandom, $urandom, $urandom, $urandom};
    twB = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    pushSchedule(keyA, twA, 1'b0);
    doLoad(keyA, twA, 1'b0);
    got = 0; cyc = 0;
    while (got < NSK && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (got == 5) begin
        key_in = keyB; tweak_in = twB; dir = 1'b1; load_valid = 1'b1;
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL busy_ready act=%b exp=0", load_ready); end
      end
      if (out_valid && out_ready) begin
        e = q.pop_front();
        checks++;
        if (subkey !== e.sk || subkey_idx !== e.idx || subkey_last !== e.last) begin
          failures++;
          $display("FAIL busy_stream idx act=%0d exp=%0d word%0d act=%h exp=%h", subkey_idx, e.idx,
                   firstDiff(subkey, e.sk), subkey[64*firstDiff(subkey, e.sk) +: 64],
                   e.sk[64*firstDiff(subkey, e.sk) +: 64]);
        end
        got++;
      end
    end
    waitIdle(ok);
    checks++;
    if (!ok || ext_key !== {refK16(keyA), keyA} || ext_tweak !== {twA[63:0] ^ twA[127:64], twA}) begin
      failures++;
      $display("FAIL busy_ext idle=%b k16 act=%h exp=%h", ok, ext_key[1087:1024], refK16(keyA));
    end
    @(negedge clk);
    load_valid = 1'b0;
    waitValid(ok);
    checks++;
    if (!ok || subkey_idx !== 5'd20 || subkey !== refSubkey(keyB, twB, 20) || ext_key !== {refK16(keyB), keyB}) begin
      failures++;
      $display("FAIL busy_reload valid=%b idx act=%0d exp=20 w0 act=%h exp=%h", ok, subkey_idx,
               subkey[63:0], refSubkey(keyB, twB, 20) & 1024'hFFFFFFFFFFFFFFFF);
    end
    waitIdle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL busy_idle timeout act=0 exp=1"); end
  endtask

  task automatic test_async_reset();
    logic [1023:0] key;
    logic [127:0]  tw;
    bit            ok;
    key = randKey();
    tw  = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    doLoad(key, tw, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      ok = out_valid && (subkey_idx == 5'd10);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_reach_idx10 act=%0d exp=10", subkey_idx); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || load_ready !== 1'b1 || subkey !== '0 || ext_key !== '0 ||
        subkey_idx !== 5'd0 || subkey_last !== 1'b0 || ext_tweak !== '0) begin
      failures++;
      $display("FAIL rst_async valid act=%b exp=0 ready act=%b exp=1 idx act=%0d exp=0 sk_nz=%b ek_nz=%b",
               out_valid, load_ready, subkey_idx, |subkey, |ext_key);
    end
    #1 rst = 1'b0;
    doLoad(key, tw, 1'b0);
    waitValid(ok);
    checks++;
    if (!ok || subkey_idx !== 5'd0 || subkey !== refSubkey(key, tw, 0)) begin
      failures++;
      $display("FAIL rst_restart valid=%b idx act=%0d exp=0", ok, subkey_idx);
    end
    waitIdle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_idle timeout act=0 exp=1"); end
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_direction(1'b0);
    test_direction(1'b1);
    test_backpressure();
    test_load_ignored();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
